scale_h_feeder: RTL

//  Upstream driver for the bilinear weighting unit in the scaler datapath. Buffers one input line,

---
 rtl/scale_h_feeder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/scale_h_feeder.sv
// Line-buffered horizontal DDA feeder for the bilinear weighting unit.
// Optional build macro SCALE_PHASE_CENTER_EN selects centre-aligned sampling phase.
module scale_h_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_W      = ADDR_WIDTH + 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_WIDTH:0]   cfg_in_width,
  input  logic [ADDR_WIDTH:0]   cfg_out_width,
  input  logic [ACC_W-1:0]      cfg_step,
  input  logic [7:0]            vcoff_a,
  input  logic [7:0]            vcoff_b,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_in_en,
  output logic                  pix_in_rdy,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [7:0]            a_coff,
  output logic [7:0]            b_coff,
  output logic [7:0]            a_coff_next,
  output logic [7:0]            b_coff_next,
  output logic                  data_en_out,
  output logic                  scale_en_out,
  output logic                  line_done,
  output logic                  cfg_err
);

  localparam logic [ADDR_WIDTH:0]   ONE_W = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ACC_W-1:0]      STEP_ONE = 256;
  localparam logic [ACC_W-1:0]      HALF_PIX = 128;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_EMIT} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0] r_line_buf [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_in_w, r_out_w, r_k;
  logic [ACC_W-1:0]      r_step, r_acc;
  logic [7:0]            r_vcoff_a, r_vcoff_b;
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [7:0]            r_a_coff, r_b_coff;
  logic                  r_den, r_sc, r_ld, r_cfg_err;

  logic                  w_accept, w_cfg_bad, w_start_line, w_last_wr, w_last_k;
  logic                  w_wr_en, w_clamp;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_int, w_int_p1, w_last_addr;
  logic [ADDR_WIDTH:0]   w_in_last, w_out_last;
  logic [7:0]            w_frac;
  logic [ACC_W-1:0]      w_start;

  assign pix_in_rdy   = (r_state != ST_EMIT);
  assign w_accept     = pix_in_en & pix_in_rdy;
  assign w_cfg_bad    = (cfg_in_width == '0) | (cfg_out_width == '0);
  assign w_start_line = (r_state == ST_IDLE) & w_accept & ~w_cfg_bad;
  assign w_in_last    = r_in_w - ONE_W;
  assign w_out_last   = r_out_w - ONE_W;
  assign w_last_wr    = ({1'b0, r_wr_ptr} == w_in_last);
  assign w_last_k     = (r_k == w_out_last);

`ifdef SCALE_PHASE_CENTER_EN
  assign w_start = (cfg_step >= STEP_ONE) ? ((cfg_step >> 1) - HALF_PIX) : '0;
`else
  assign w_start = '0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // NOTE: next state gets its default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_line) w_state_nxt = (cfg_in_width == ONE_W) ? ST_EMIT : ST_FILL;
      ST_FILL: if (w_accept && w_last_wr) w_state_nxt = ST_EMIT;
      ST_EMIT: if (w_last_k) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The first pixel of a line lands at address 0 in the same cycle the line is opened.
  assign w_wr_en   = w_start_line | ((r_state == ST_FILL) & w_accept);
  assign w_wr_addr = (r_state == ST_IDLE) ? '0 : r_wr_ptr;

  // NOTE: the line buffer carries no reset; every location read is written earlier in the line.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_line_buf[w_wr_addr] <= pix_in;
  end

  assign w_int       = r_acc[ACC_W-1:8];
  assign w_frac      = r_acc[7:0];
  assign w_int_p1    = w_int + ONE_A;
  assign w_last_addr = w_in_last[ADDR_WIDTH-1:0];
  assign w_clamp     = ({1'b0, w_int} >= w_in_last);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_wr_ptr  <= '0;
      r_in_w    <= '0;
      r_out_w   <= '0;
      r_k       <= '0;
      r_step    <= '0;
      r_acc     <= '0;
      r_vcoff_a <= '0;
      r_vcoff_b <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_a_coff  <= '0;
      r_b_coff  <= '0;
      r_den     <= 1'b0;
      r_sc      <= 1'b0;
      r_ld      <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_den     <= 1'b0;
      r_sc      <= 1'b0;
      r_ld      <= 1'b0;
      r_cfg_err <= w_cfg_bad;
      case (r_state)
        ST_IDLE: if (w_start_line) begin
          r_in_w    <= cfg_in_width;
          r_out_w   <= cfg_out_width;
          r_step    <= cfg_step;
          r_acc     <= w_start;
          r_vcoff_a <= vcoff_a;
          r_vcoff_b <= vcoff_b;
          r_wr_ptr  <= ONE_A;
          r_k       <= '0;
        end
        ST_FILL: if (w_accept) r_wr_ptr <= r_wr_ptr + ONE_A;
        ST_EMIT: begin
          r_acc <= r_acc + r_step;
          r_k   <= r_k + ONE_W;
          r_den <= 1'b1;
          r_sc  <= (r_k == '0);
          r_ld  <= w_last_k;
          if (w_clamp) begin
            r_a      <= r_line_buf[w_last_addr];
            r_b      <= r_line_buf[w_last_addr];
            r_a_coff <= 8'hFF;
            r_b_coff <= 8'h00;
          end else begin
            r_a      <= r_line_buf[w_int];
            r_b      <= r_line_buf[w_int_p1];
            r_a_coff <= ~w_frac;
            r_b_coff <= w_frac;
          end
        end
        default: ;
      endcase
    end
  end

  assign a            = r_a;
  assign b            = r_b;
  assign a_coff       = r_a_coff;
  assign b_coff       = r_b_coff;
  assign a_coff_next  = r_vcoff_a;
  assign b_coff_next  = r_vcoff_b;
  assign data_en_out  = r_den;
  assign scale_en_out = r_sc;
  assign line_done    = r_ld;
  assign cfg_err      = r_cfg_err;

endmodule
